seg7_display_driver: RTL and testbench

- Downstream of the core's result path: latches the 16-bit result (`val`) or an error code and drives the board's 4-digit, active-low seven-segment display via a time-multiplexed scan.
- Replaces the ad-hoc digit logic in the top level.
- The core pulses `value_valid` on reaching Halt or Error; this block owns all scanning, blanking and blink timing.

---
 rtl/lisp_defs.sv | 15 +
 rtl/seg7_hex_decode.sv | 30 +++
 rtl/seg7_display_driver.sv | 132 +++++++++++++
 tb/tb_seg7_display_driver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lisp_defs.sv
// Shared display definitions for the result/error seven-segment driver.
// Mode encodings match the core's mode field; segment constants are active-low.
package lisp_defs;

    typedef enum logic [1:0] {
        DISP_VALUE = 2'd0,
        DISP_ERROR = 2'd1,
        DISP_BLANK = 2'd2
    } disp_mode_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (gfedcba, dp off).
module seg7_hex_decode (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/seg7_display_driver.sv
// Latches the core's result or error code and scans it onto a 4-digit
// active-low seven-segment display with ghost blanking and error blink.
module seg7_display_driver
    import lisp_defs::*;
#(
    parameter int DigitCycles   = 100_000,
    parameter int BlinkScans    = 250,
    parameter int LeadZeroBlank = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        value_valid,
    input  logic [15:0] value_in,
    input  logic [7:0]  error_code,
    input  logic [1:0]  mode,
    output logic [7:0]  cathodes,
    output logic [3:0]  anodes,
    output logic        scan_tick
);

    localparam int CntW   = $clog2(DigitCycles);
    localparam int BlinkW = (BlinkScans > 1) ? $clog2(BlinkScans) : 1;

    logic [CntW-1:0]   slot_cnt;
    logic [1:0]        digit_idx;
    logic [BlinkW-1:0] blink_cnt;
    logic              blink_phase;
    logic [15:0]       shown_value;
    logic [7:0]        shown_err;
    logic [1:0]        shown_mode;
    logic [7:0]        slot_seg;

    logic              slot_end;
    logic              scan_end;
    logic              lead_blank;
    logic [3:0]        nibble_sel;
    logic [7:0]        hex_seg;
    logic [7:0]        slot_pattern;

    assign slot_end = (slot_cnt == CntW'(DigitCycles - 1));
    assign scan_end = slot_end && (digit_idx == 2'd3);

    // A digit is a leading zero when it and every nibble above it are zero.
    assign lead_blank = (LeadZeroBlank != 0) && (digit_idx != 2'd0) &&
                        ((shown_value >> {digit_idx, 2'b00}) == 16'h0000);

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_sel),
        .seg    (hex_seg)
    );

    always_comb begin
        nibble_sel   = shown_value[{digit_idx, 2'b00} +: 4];
        slot_pattern = SEG_BLANK;
        case (shown_mode)
            DISP_VALUE: begin
                slot_pattern = lead_blank ? SEG_BLANK : hex_seg;
            end
            DISP_ERROR: begin
                nibble_sel = (digit_idx == 2'd1) ? shown_err[7:4] : shown_err[3:0];
                if (blink_phase) begin
                    slot_pattern = SEG_BLANK;
                end else if (digit_idx == 2'd3) begin
                    slot_pattern = SEG_E;
                end else if (digit_idx == 2'd2) begin
                    slot_pattern = SEG_R;
                end else begin
                    slot_pattern = hex_seg;
                end
            end
            default: slot_pattern = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= scan_end;
            if (slot_end) begin
                slot_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                slot_cnt  <= slot_cnt + CntW'(1);
            end
        end
    end

    // A new strobe always restarts the blink so fresh errors appear immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shown_value <= 16'h0000;
            shown_err   <= 8'h00;
            shown_mode  <= DISP_BLANK;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (value_valid) begin
            shown_value <= value_in;
            shown_err   <= error_code;
            shown_mode  <= mode;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (scan_end) begin
            if (blink_cnt == BlinkW'(BlinkScans - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + BlinkW'(1);
            end
        end
    end

    // The digit pattern is frozen during the blanking cycle so a strobe never
    // changes what an already-enabled digit shows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_seg <= SEG_BLANK;
            anodes   <= 4'hF;
            cathodes <= SEG_BLANK;
        end else if (slot_cnt == '0) begin
            slot_seg <= slot_pattern;
            anodes   <= 4'hF;
            cathodes <= SEG_BLANK;
        end else begin
            anodes   <= ~(4'b0001 << digit_idx);
            cathodes <= slot_seg;
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Directed self-checking bench for seg7_display_driver with short slots
// (4 clocks per digit, blink every 2 scans) so whole scans are cheap to check.
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        value_valid = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [7:0]  error_code = 8'h00;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  cathodes;
    logic [3:0]  anodes;
    logic        scan_tick;

    int errors = 0;
    int checks = 0;
    int k = 0;

    seg7_display_driver #(
        .DigitCycles   (4),
        .BlinkScans    (2),
        .LeadZeroBlank (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_valid (value_valid),
        .value_in    (value_in),
        .error_code  (error_code),
        .mode        (mode),
        .cathodes    (cathodes),
        .anodes      (anodes),
        .scan_tick   (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at k=%0d: observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic strobe_aligned(input logic [15:0] v, input logic [7:0] e, input logic [1:0] m);
        while (k % 16 != 15) tick();
        value_in    = v;
        error_code  = e;
        mode        = m;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    // Expected: slot starts are dark, then digit d shows segs[d] for 3 cycles.
    task automatic check_scan(input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0, input int n);
        logic [7:0] segs [4];
        int pos;
        int d;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int i = 0; i < n; i++) begin
            tick();
            pos = (k - 1) % 16;
            d   = pos / 4;
            if (pos % 4 == 0) begin
                chk("anodes_gap", {4'h0, anodes}, 8'h0F);
                chk("cathodes_gap", cathodes, 8'hFF);
            end else begin
                chk("anodes", {4'h0, anodes}, {4'h0, ~(4'b0001 << d)});
                chk("cathodes", cathodes, segs[d]);
            end
            chk("scan_tick", {7'b0, scan_tick}, {7'b0, (k % 16 == 0)});
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("reset_anodes", {4'h0, anodes}, 8'h0F);
        chk("reset_cathodes", cathodes, 8'hFF);
        chk("reset_scan_tick", {7'b0, scan_tick}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        k = 0;

        // Blank after reset, scan still running
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);

        strobe_aligned(16'hDEAD, 8'h00, 2'd0);
        check_scan(8'hA1, 8'h86, 8'h88, 8'hA1, 16);

        strobe_aligned(16'h0003, 8'h00, 2'd0);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hB0, 16);
        strobe_aligned(16'h0000, 8'h00, 2'd0);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hC0, 16);
        strobe_aligned(16'h00F0, 8'h00, 2'd0);
        check_scan(8'hFF, 8'hFF, 8'h8E, 8'hC0, 16);

        // Error blink: two visible scans, two dark, then visible again
        strobe_aligned(16'h0000, 8'h2C, 2'd1);
        check_scan(8'h86, 8'hAF, 8'hA4, 8'hC6, 16);
        check_scan(8'h86, 8'hAF, 8'hA4, 8'hC6, 16);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);
        check_scan(8'h86, 8'hAF, 8'hA4, 8'hC6, 16);
        check_scan(8'h86, 8'hAF, 8'hA4, 8'hC6, 16);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 15);
        // Restrobe during the dark phase brings the digits straight back
        strobe_aligned(16'h0000, 8'h2C, 2'd1);
        check_scan(8'h86, 8'hAF, 8'hA4, 8'hC6, 16);
        check_scan(8'h86, 8'hAF, 8'hA4, 8'hC6, 16);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);

        strobe_aligned(16'h0000, 8'h00, 2'd3);
        check_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);

        // Mid-slot strobe on digit 1
        strobe_aligned(16'hDEAD, 8'h00, 2'd0);
        check_scan(8'hA1, 8'h86, 8'h88, 8'hA1, 16);
        while (k % 16 != 6) tick();
        value_in    = 16'h1234;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        chk("mid_anodes_a", {4'h0, anodes}, 8'h0D);
        chk("mid_cathodes_a", cathodes, 8'h88);
        tick();
        chk("mid_anodes_b", {4'h0, anodes}, 8'h0D);
        chk("mid_cathodes_b", cathodes, 8'h88);
        tick();
        chk("mid_gap", cathodes, 8'hFF);
        tick();
        chk("mid_next_anodes", {4'h0, anodes}, 8'h0B);
        chk("mid_next_cathodes", cathodes, 8'hA4);
        while (k % 16 != 0) tick();
        check_scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 16);

        // Asynchronous reset mid-slot
        while (k % 16 != 10) tick();
        chk("pre_rst_anodes", {4'h0, anodes}, 8'h0B);
        rst = 1'b0;
        #1;
        chk("async_rst_anodes", {4'h0, anodes}, 8'h0F);
        chk("async_rst_cathodes", cathodes, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        k = 0;
        tick();
        chk("post_rst_c1_anodes", {4'h0, anodes}, 8'h0F);
        chk("post_rst_c1_cathodes", cathodes, 8'hFF);
        tick();
        chk("post_rst_c2_anodes", {4'h0, anodes}, 8'h0E);
        chk("post_rst_c2_cathodes", cathodes, 8'hFF);
        strobe_aligned(16'h00F0, 8'h00, 2'd0);
        check_scan(8'hFF, 8'hFF, 8'h8E, 8'hC0, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
